// File: rtl/cdb_arbiter_if.sv
// Common data bus handshake bundle: per-unit request side plus registered broadcast.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if #(
   parameter int NUM_UNITS  = 3,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 6
);
   logic [NUM_UNITS-1:0]            unit_rts;
   logic [NUM_UNITS*DATA_WIDTH-1:0] unit_data;
   logic [NUM_UNITS*TAG_WIDTH-1:0]  unit_source;
   logic [NUM_UNITS-1:0]            CDB_xmit;
   logic [DATA_WIDTH-1:0]           CDB_data;
   logic [TAG_WIDTH-1:0]            CDB_source;
   logic                            CDB_write;

   modport master (output unit_rts, unit_data, unit_source,
                   input  CDB_xmit, CDB_data, CDB_source, CDB_write);
   modport slave  (input  unit_rts, unit_data, unit_source,
                   output CDB_xmit, CDB_data, CDB_source, CDB_write);
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one registered one-hot grant and broadcast per cycle.
// Define CDB_ARBITER_STATS_EN to add grant/conflict counters (stat_grants, stat_conflicts).
module cdb_arbiter #(
   parameter int NUM_UNITS  = 3,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 6
) (
   input  logic         clock,
   input  logic         reset_n,
   cdb_arbiter_if.slave cdb
`ifdef CDB_ARBITER_STATS_EN
   ,
   output logic [31:0]  stat_grants,
   output logic [31:0]  stat_conflicts
`endif
);
   localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [NUM_UNITS-1:0]  xmit_q, xmit_d, eligible;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [TAG_WIDTH-1:0]  source_q, source_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [PTR_W-1:0]      idx;
   logic [PTR_W:0]        sum;

   logic [DATA_WIDTH-1:0] udata [NUM_UNITS];
   logic [TAG_WIDTH-1:0]  usrc  [NUM_UNITS];

   for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
      assign udata[g] = cdb.unit_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign usrc[g]  = cdb.unit_source[g*TAG_WIDTH +: TAG_WIDTH];
   end

   // A unit being broadcast this cycle still holds rts; masking it stops a double grant.
   assign eligible = cdb.unit_rts & ~xmit_q;

   always_comb begin
      xmit_d   = '0;
      write_d  = 1'b0;
      data_d   = data_q;
      source_d = source_q;
      ptr_d    = ptr_q;
      idx      = '0;
      sum      = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_UNITS)) sum = sum - (PTR_W+1)'(NUM_UNITS);
         idx = sum[PTR_W-1:0];
         if (!write_d && eligible[idx]) begin
            write_d      = 1'b1;
            xmit_d[idx]  = 1'b1;
            data_d       = udata[idx];
            source_d     = usrc[idx];
            ptr_d        = (idx == PTR_W'(NUM_UNITS-1)) ? '0 : idx + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         xmit_q   <= '0;
         write_q  <= 1'b0;
         data_q   <= '0;
         source_q <= '0;
         ptr_q    <= '0;
      end else begin
         xmit_q   <= xmit_d;
         write_q  <= write_d;
         data_q   <= data_d;
         source_q <= source_d;
         ptr_q    <= ptr_d;
      end
   end

   assign cdb.CDB_xmit   = xmit_q;
   assign cdb.CDB_write  = write_q;
   assign cdb.CDB_data   = data_q;
   assign cdb.CDB_source = source_q;

`ifdef CDB_ARBITER_STATS_EN
   logic [31:0] grants_q, conflicts_q;
   logic        multi;

   // More than one bit set: clearing the lowest set bit leaves something behind.
   assign multi = (eligible & (eligible - NUM_UNITS'(1))) != '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grants_q    <= '0;
         conflicts_q <= '0;
      end else begin
         grants_q    <= grants_q + 32'(write_d);
         conflicts_q <= conflicts_q + 32'(multi);
      end
   end

   assign stat_grants    = grants_q;
   assign stat_conflicts = conflicts_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin reference model checked every cycle,
// plus literal expectations on the hand-worked scenarios.
module tb_cdb_arbiter;
   localparam int N  = 3;
   localparam int DW = 32;
   localparam int TW = 6;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   cdb_arbiter_if #(.NUM_UNITS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

   logic [N-1:0]  rts;
   logic [DW-1:0] u_data [N];
   logic [TW-1:0] u_src  [N];

   assign bus.unit_rts    = rts;
   assign bus.unit_data   = {u_data[2], u_data[1], u_data[0]};
   assign bus.unit_source = {u_src[2], u_src[1], u_src[0]};

`ifdef CDB_ARBITER_STATS_EN
   logic [31:0] stat_grants, stat_conflicts;
`endif

   cdb_arbiter #(.NUM_UNITS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .cdb            (bus)
`ifdef CDB_ARBITER_STATS_EN
      ,
      .stat_grants    (stat_grants),
      .stat_conflicts (stat_conflicts)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // Reference model: pointer, index of the unit on the bus (-1 = none), broadcast payload.
   int            m_ptr, m_win;
   logic [DW-1:0] m_data;
   logic [TW-1:0] m_src;
   int unsigned   m_grants, m_conf;

   function automatic int rr_pick(input int ptr, input int last, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (ptr + k) % N;
         if (r[i] && i != last) return i;
      end
      return -1;
   endfunction

   function automatic int n_elig(input int last, input logic [N-1:0] r);
      int c;
      c = 0;
      for (int i = 0; i < N; i++) if (r[i] && i != last) c++;
      return c;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_ptr <= 0; m_win <= -1; m_data <= '0; m_src <= '0;
         m_grants <= 0; m_conf <= 0;
      end else begin
         m_win <= rr_pick(m_ptr, m_win, rts);
         if (rr_pick(m_ptr, m_win, rts) >= 0) begin
            m_ptr    <= (rr_pick(m_ptr, m_win, rts) + 1) % N;
            m_data   <= u_data[rr_pick(m_ptr, m_win, rts)];
            m_src    <= u_src[rr_pick(m_ptr, m_win, rts)];
            m_grants <= m_grants + 1;
         end
         if (n_elig(m_win, rts) >= 2) m_conf <= m_conf + 1;
      end
   end

   logic [N-1:0] exp_x;
   always @(negedge clock) begin
      if (chk_en) begin
         exp_x = (m_win >= 0) ? N'(1 << m_win) : '0;
         vectors++;
         if ({bus.CDB_xmit, bus.CDB_write, bus.CDB_data, bus.CDB_source} !==
             {exp_x, (m_win >= 0), m_data, m_src}) begin
            miscompares++;
            $display("FAIL model t=%0t: got xmit=%b write=%b data=%h src=%h, expected xmit=%b write=%b data=%h src=%h",
                     $time, bus.CDB_xmit, bus.CDB_write, bus.CDB_data, bus.CDB_source,
                     exp_x, (m_win >= 0), m_data, m_src);
         end
`ifdef CDB_ARBITER_STATS_EN
         vectors++;
         if (stat_grants !== m_grants || stat_conflicts !== m_conf) begin
            miscompares++;
            $display("FAIL stats t=%0t: got grants=%0d conflicts=%0d, expected %0d %0d",
                     $time, stat_grants, stat_conflicts, m_grants, m_conf);
         end
`endif
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Present rts, let one edge pass, return just after the following falling edge.
   task automatic step(input logic [N-1:0] r);
      rts = r;
      @(posedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic chk_bus(input string nm, input logic [N-1:0] x, input logic [DW-1:0] d, input logic [TW-1:0] s);
      chk({nm, " xmit"},  64'(bus.CDB_xmit),   64'(x));
      chk({nm, " write"}, 64'(bus.CDB_write),  64'(x != '0));
      chk({nm, " data"},  64'(bus.CDB_data),   64'(d));
      chk({nm, " src"},   64'(bus.CDB_source), 64'(s));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      rts     = '0;
      for (int i = 0; i < N; i++) begin u_data[i] = '0; u_src[i] = '0; end
      repeat (2) @(negedge clock);
      #1;
      chk_en = 1'b1;
      chk_bus("reset", 3'b000, 32'h0, 6'h0);
`ifdef CDB_ARBITER_STATS_EN
      chk("reset grants", 64'(stat_grants), 64'd0);
      chk("reset conflicts", 64'(stat_conflicts), 64'd0);
`endif
      reset_n = 1'b1;

      // Single request, held through its xmit cycle
      u_data[0] = 32'h0000_0007; u_src[0] = 6'b000010;
      step(3'b001); chk_bus("single grant", 3'b001, 32'h7, 6'd2);
      step(3'b001); chk_bus("single no regrant", 3'b000, 32'h7, 6'd2);
      step(3'b000);

      // All three from pointer 0, each dropping after its xmit cycle
      do_reset();
      u_data[0] = 32'h11; u_src[0] = 6'd1;
      u_data[1] = 32'h22; u_src[1] = 6'd2;
      u_data[2] = 32'h33; u_src[2] = 6'd3;
      step(3'b111); chk_bus("all g0", 3'b001, 32'h11, 6'd1);
      step(3'b111); chk_bus("all g1", 3'b010, 32'h22, 6'd2);
      step(3'b110); chk_bus("all g2", 3'b100, 32'h33, 6'd3);
      step(3'b100); chk_bus("all idle", 3'b000, 32'h33, 6'd3);
      step(3'b000);
      // Pointer back at 0: unit 0 beats unit 1
      step(3'b011); chk_bus("ptr back at 0", 3'b001, 32'h11, 6'd1);
      step(3'b011); chk_bus("ptr then 1", 3'b010, 32'h22, 6'd2);
      step(3'b010);
      step(3'b000);

      // Wrap: pointer is 2, units 0 and 2 request
      u_data[0] = 32'hA0; u_data[2] = 32'hC2;
      step(3'b101); chk_bus("wrap u2 first", 3'b100, 32'hC2, 6'd3);
      step(3'b101); chk_bus("wrap u0 next", 3'b001, 32'hA0, 6'd1);
      step(3'b001); chk_bus("wrap idle", 3'b000, 32'hA0, 6'd1);
      step(3'b000);

      // One unit holding rts forever: grant every other cycle
      u_data[1] = 32'hBEEF; u_src[1] = 6'd9;
      for (int c = 0; c < 6; c++) begin
         step(3'b010);
         chk("toggle xmit", 64'(bus.CDB_xmit), (c % 2 == 0) ? 64'b010 : 64'b000);
      end
      step(3'b000);

      // Reset asserted mid-broadcast, rts kept high across it
      u_data[2] = 32'h5555_AAAA; u_src[2] = 6'd33;
      step(3'b100); chk_bus("pre-reset grant", 3'b100, 32'h5555_AAAA, 6'd33);
      reset_n = 1'b0;
      #1;
      chk_bus("async reset", 3'b000, 32'h0, 6'h0);
      @(posedge clock); @(negedge clock); #1;
      reset_n = 1'b1;
      step(3'b100); chk_bus("regrant after reset", 3'b100, 32'h5555_AAAA, 6'd33);
      step(3'b100); chk_bus("no regrant", 3'b000, 32'h5555_AAAA, 6'd33);
      step(3'b000);

      // Flushed request: unit 1 drops rts without ever being granted
      step(3'b011); chk_bus("flush u0 wins", 3'b001, 32'hA0, 6'd1);
      step(3'b001); chk_bus("flush nothing", 3'b000, 32'hA0, 6'd1);
      step(3'b000);

      // Continuous full load from pointer 1
      for (int c = 0; c < 10; c++) begin
         step(3'b111);
         chk("rr full load", 64'(bus.CDB_xmit), 64'(3'b001 << ((1 + c) % 3)));
      end
      step(3'b000);
      step(3'b000);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Responder side of the common data bus (CDB) request-to-send / transmit handshake.
- Each functional unit (adder, multiplier, load unit) raises `CDB_rts` with its result and source tag. The arbiter grants one unit per cycle with a one-cycle `CDB_xmit` pulse.
- It drives the registered broadcast (`CDB_data`, `CDB_source`, `CDB_write`) seen by the register file and all reservation stations.
- Replaces the single-unit grant flop in the processor top level once more than one execution unit exists.

Parameters:
- NUM_UNITS, 3, number of requesting functional units (index 0 = adder).
- DATA_WIDTH, 32, width of the signed result broadcast.
- TAG_WIDTH, 6, width of the reservation-station source tag.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- unit_rts  input  NUM_UNITS  per-unit request-to-send; held high until granted.
- unit_data  input  NUM_UNITS*DATA_WIDTH  per-unit result, unit i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- unit_source  input  NUM_UNITS*TAG_WIDTH  per-unit source tag, same packing.
- CDB_xmit  output  NUM_UNITS  one-hot grant pulse, registered.
- CDB_data  output  DATA_WIDTH  broadcast result, registered.
- CDB_source  output  TAG_WIDTH  broadcast source tag, registered.
- CDB_write  output  1  broadcast valid, registered.

Behaviour:
- Reset (reset_n low, asynchronous): `CDB_xmit`=0, `CDB_write`=0, `CDB_data`=0, `CDB_source`=0, round-robin pointer=0. Outputs are cleared immediately, even mid-broadcast. The interrupted broadcast is lost; the unit keeps `rts` high and is re-arbitrated after reset release.
- Eligibility per cycle: `eligible[i] = unit_rts[i] & ~CDB_xmit[i]`.
  - A unit granted this cycle still shows `rts` high and must not be granted again next cycle.
  - Consequence: one unit receives at most one grant every two cycles (same rule as the existing single-unit grant flop).
- Arbitration: round-robin.
  - Search starts at the pointer and wraps from NUM_UNITS-1 to 0.
  - The first eligible unit i wins.
- On the rising edge after a win:
  - `CDB_xmit` = one-hot(i).
  - `CDB_write` = 1.
  - `CDB_data` = unit_data[i] and `CDB_source` = unit_source[i], both sampled on that edge.
  - Pointer = (i+1) mod NUM_UNITS.
- No eligible unit: `CDB_xmit`=0, `CDB_write`=0, pointer unchanged. `CDB_data` and `CDB_source` hold their last values.
- Latency: `rts` rising at edge N (visible before edge N+1) gives `xmit` and `write` high during cycle N+1. Minimum request-to-broadcast latency is 1 cycle.
- Unit-side contract:
  - Data and tag stay stable while `rts` is high.
  - `rts` is dropped on the edge following the `xmit` cycle.
  - A unit may re-raise `rts` for a new result two cycles after it was granted.
- Throughput: one broadcast per cycle when at least two units request; back-to-back grants go to different units.
- Simultaneous requests: all-request case grants in pointer order, e.g. pointer=0 gives 0,1,2,0,...
- Grant independence: `CDB_xmit` is exactly one-hot or zero. `CDB_write` equals the OR of `CDB_xmit`.
- `rts` dropped without a grant (unit flushed): no grant issued, no error.

Optional Feature:
- Macro: `CDB_ARBITER_STATS_EN`.
- When defined, adds two ports:
  - stat_grants  output 32: count of cycles with `CDB_write`=1.
  - stat_conflicts  output 32: count of cycles where more than one unit was eligible.
- Both counters reset to 0 asynchronously and wrap modulo 2^32.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single request: `unit_rts`=3'b001, data=32'h0000_0007, source=6'b000010 → next cycle `CDB_xmit`=3'b001, `CDB_write`=1, `CDB_data`=7, `CDB_source`=2; unit holds `rts` through the xmit cycle → no second grant.
- All three request from reset and hold, each dropping `rts` after its xmit cycle → grants 001, 010, 100 in consecutive cycles, pointer returns to 0.
- Wrap/fairness: pointer=2, units 0 and 2 request → unit 2 granted first, unit 0 next cycle.
- Single unit re-requesting continuously (`rts` held high forever) → `CDB_xmit` toggles 1,0,1,0; broadcast every other cycle.
- Reset asserted during a xmit cycle → `CDB_xmit`, `CDB_write` and `CDB_data` go 0 before the next edge. After release with `rts` still high → grant reissued with the same data.
- With `CDB_ARBITER_STATS_EN`: 10 cycles of all units requesting → stat_grants=10; stat_conflicts counts each cycle with ≥2 eligible units (expected 10). After reset, both counters read 0.
